// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic controllers: state encoding and a
// constant-foldable ceil(log2) helper.
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one shared full_adder processes the operands LSB first,
// one bit per clock, behind a start/busy/done handshake.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int unsigned     CntW    = clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cmsb_q, cmsb_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              co_q, co_d;
    logic              fa_sum;
    logic              fa_cout;

    full_adder u_full_adder (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        s_d     = s_q;
        co_d    = co_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_sh_d  = a;
                    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            StRun: begin
                res_d   = WIDTH'({fa_sum, res_q} >> 1);
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    cmsb_d  = carry_q;
                    s_d     = WIDTH'({fa_sum, res_q} >> 1);
                    co_d    = fa_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign s    = s_q;
    assign co   = co_q;
    // cmsb and co only change together on the completing edge, so ov holds with them.
    assign ov   = cmsb_q ^ co_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): cycle-level behavioural model plus
// directed literal checks and randomized traffic.
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ov;

    int n_vec = 0;
    int n_err = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ov    (ov)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;

    // Result from plain integer arithmetic on the operand values.
    function automatic res_t compute(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic op_sub);
        res_t r;
        int   ux, uy, sx, sy, sr, ur;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (op_sub) begin
            ur   = ux - uy;
            sr   = sx - sy;
            r.co = (ux >= uy);
        end else begin
            ur   = ux + uy;
            sr   = sx + sy;
            r.co = (ur > 255);
        end
        r.s  = W'(ur);
        r.ov = (sr > 127) || (sr < -128);
        return r;
    endfunction

    // Model: phase 0 idle, 1..W busy, W+1 done pulse.
    int   m_phase = 0;
    res_t m_pend  = '0;
    res_t m_out   = '0;
    bit   chk_en  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_out   <= '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_pend  <= compute(a, b, sub);
                m_phase <= 1;
            end
        end else if (m_phase < int'(W)) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == int'(W)) begin
            m_phase <= int'(W) + 1;
            m_out   <= m_pend;
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic eb, ed;
            eb = (m_phase >= 1) && (m_phase <= int'(W));
            ed = (m_phase == int'(W) + 1);
            n_vec++;
            if (busy !== eb || done !== ed || s !== m_out.s || co !== m_out.co
                || ov !== m_out.ov) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got busy=%b done=%b s=%h co=%b ov=%b want busy=%b done=%b s=%h co=%b ov=%b",
                         $time, busy, done, s, co, ov, eb, ed, m_out.s, m_out.co, m_out.ov);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsub,
                          input logic [W-1:0] es, input logic eco, input logic eov,
                          input string name);
        int dc, nbusy;
        bit got;
        @(negedge clk); #1;
        a = ta; b = tb_; sub = tsub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
        got = 1'b0; dc = 0; nbusy = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1;
                dc  = c;
            end
        end
        check({name, "_done_cycle"}, dc, W + 1);
        check({name, "_busy_cycles"}, nbusy, W);
        check({name, "_s"}, int'(s), int'(es));
        check({name, "_co"}, int'(co), int'(eco));
        check({name, "_ov"}, int'(ov), int'(eov));
    endtask

    initial begin
        int ndone;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_s", int'(s), 0);
        rst_n = 1'b1;

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "add_plain");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_carry");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf");
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_borrow");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");

        // start held high with operands changing every cycle.
        @(negedge clk); #1;
        start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            if (done) ndone++;
            #1;
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
        end
        start = 1'b0;
        check("held_start_done_count", ndone, 5);

        // Abort in cycle 4 of RUN.
        repeat (2) @(negedge clk);
        #1;
        a = 8'hC3; b = 8'h5A; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_s", int'(s), 0);
        check("abort_co", int'(co), 0);
        check("abort_ov", int'(ov), 0);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

        // Random traffic, including start during RUN and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            sub   = 1'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
